// File: rtl/ex_muldiv_seq_pkg.sv
// Shared definitions for the RV32M multi-cycle multiply/divide unit.
// Contents: datapath widths, the sequencer state enum, M-extension funct7/funct3
// encodings and the EX-stage decode helper is_muldiv_f().
package muldiv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ITER_CNT_W = 6;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } muldiv_state_t;

    // True for an OP-opcode instruction carrying the M-extension funct7.
    function automatic logic is_muldiv_f(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPCODE_OP) && (funct7 == MULDIV_FUNCT7);
    endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// EX-stage <-> muldiv sequencer interface.
// master (EX stage) drives: op_valid, funct3, opr_a, opr_b, rd, flush.
// slave  (sequencer) drives: stall, res_valid, res, res_rd.
interface ex_muldiv_seq_if;
    import muldiv_pkg::*;

    logic            op_valid;
    logic [2:0]      funct3;
    logic [XLEN-1:0] opr_a;
    logic [XLEN-1:0] opr_b;
    logic [4:0]      rd;
    logic            flush;
    logic            stall;
    logic            res_valid;
    logic [XLEN-1:0] res;
    logic [4:0]      res_rd;

    modport master (
        output op_valid, funct3, opr_a, opr_b, rd, flush,
        input  stall, res_valid, res, res_rd
    );

    modport slave (
        input  op_valid, funct3, opr_a, opr_b, rd, flush,
        output stall, res_valid, res, res_rd
    );

endinterface

// File: rtl/ex_muldiv_seq_core.sv
// muldiv_core: iteration datapath for the sequencer.
// Holds a 2*XLEN accumulator and an XLEN-bit multiplicand/divisor register.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : load accumulator and divisor/multiplicand
//   load_acc_i   : accumulator load value
//   load_d_i     : multiplicand/divisor load value
//   step_mul_i   : one shift-add step (multiplier in acc low half, product builds from top)
//   step_div_i   : one restoring shift-subtract step (remainder high, quotient low)
//   acc_o        : accumulator contents
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [2*XLEN-1:0] load_acc_i,
    input  logic [XLEN-1:0]   load_d_i,
    input  logic              step_mul_i,
    input  logic              step_div_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   d_q, d_d;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     sub_diff;

    always_comb begin
        add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, d_q};
        // Partial remainder shifted left by one with the next dividend bit.
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        sub_diff = rem_sh - {1'b0, d_q};
        acc_d    = acc_q;
        d_d      = d_q;
        if (load_i) begin
            acc_d = load_acc_i;
            d_d   = load_d_i;
        end else if (step_mul_i) begin
            // Carry-out of the add becomes the new MSB after the right shift.
            if (acc_q[0]) begin
                acc_d = {add_sum, acc_q[XLEN-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*XLEN-1:1]};
            end
        end else if (step_div_i) begin
            // Borrow out (bit XLEN) means the trial subtract failed: restore.
            if (!sub_diff[XLEN]) begin
                acc_d = {sub_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            d_q   <= '0;
        end else begin
            acc_q <= acc_d;
            d_q   <= d_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: multi-cycle RV32M sequencer beside the EX-stage ALU.
// Accepts an M-ext op, runs 32 multiply or divide iterations in muldiv_core,
// stalls the pipeline meanwhile and pulses res_valid for one cycle with the result.
//   clk, rst : clock, synchronous active-high reset
//   mdu_io   : ex_muldiv_seq_if.slave (operands/flush in, stall/result out)
module ex_muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_seq_if.slave  mdu_io
);

    muldiv_state_t         state_q, state_d;
    logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            f3_q, f3_d;
    logic [4:0]            rd_q, rd_d;
    logic                  neg_q, neg_d;
    logic [XLEN-1:0]       res_q, res_d;
    logic [4:0]            res_rd_q, res_rd_d;

    logic                  load;
    logic                  step_mul;
    logic                  step_div;
    logic [2*XLEN-1:0]     load_acc;
    logic [2*XLEN-1:0]     acc;

    logic                  signed_a, signed_b;
    logic                  a_neg, b_neg;
    logic [XLEN-1:0]       mag_a, mag_b;
    logic                  div_zero, div_ovf;
    logic [2*XLEN-1:0]     prod;
    logic [XLEN-1:0]       quo, rem;
    logic [XLEN-1:0]       fix_res;

    // Operand conditioning at accept time.
    always_comb begin
        signed_a = (mdu_io.funct3 == F3_MULH) || (mdu_io.funct3 == F3_MULHSU) ||
                   (mdu_io.funct3 == F3_DIV)  || (mdu_io.funct3 == F3_REM);
        signed_b = (mdu_io.funct3 == F3_MULH) || (mdu_io.funct3 == F3_DIV) ||
                   (mdu_io.funct3 == F3_REM);
        a_neg    = signed_a & mdu_io.opr_a[XLEN-1];
        b_neg    = signed_b & mdu_io.opr_b[XLEN-1];
        mag_a    = a_neg ? (~mdu_io.opr_a + 1'b1) : mdu_io.opr_a;
        mag_b    = b_neg ? (~mdu_io.opr_b + 1'b1) : mdu_io.opr_b;
        div_zero = mdu_io.funct3[2] && (mdu_io.opr_b == '0);
        div_ovf  = ((mdu_io.funct3 == F3_DIV) || (mdu_io.funct3 == F3_REM)) &&
                   (mdu_io.opr_a == {1'b1, {(XLEN-1){1'b0}}}) && (mdu_io.opr_b == '1);
        // Fast paths preload the final {remainder, quotient} with no sign fixup.
        if (div_zero) begin
            load_acc = {mdu_io.opr_a, {XLEN{1'b1}}};
        end else if (div_ovf) begin
            load_acc = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
        end else begin
            load_acc = {{XLEN{1'b0}}, mag_a};
        end
    end

    // Sign fixup and result select from the finished accumulator.
    always_comb begin
        prod = neg_q ? (~acc + 1'b1) : acc;
        quo  = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem  = neg_q ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        unique case (f3_q)
            F3_MUL:                       fix_res = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = quo;
            default:                      fix_res = rem;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        f3_d             = f3_q;
        rd_d             = rd_q;
        neg_d            = neg_q;
        res_d            = res_q;
        res_rd_d         = res_rd_q;
        load             = 1'b0;
        step_mul         = 1'b0;
        step_div         = 1'b0;
        mdu_io.stall     = 1'b0;
        mdu_io.res_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                mdu_io.stall = mdu_io.op_valid & ~mdu_io.flush;
                if (mdu_io.op_valid && !mdu_io.flush) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    f3_d  = mdu_io.funct3;
                    rd_d  = mdu_io.rd;
                    // REM takes the dividend sign; all others the operand sign product.
                    neg_d = (div_zero || div_ovf) ? 1'b0 :
                            (mdu_io.funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
                    if (div_zero || div_ovf) begin
                        state_d = DONE;
                    end else begin
                        state_d = mdu_io.funct3[2] ? DIV : MUL;
                    end
                end
            end
            MUL, DIV: begin
                if (mdu_io.flush) begin
                    state_d = IDLE;
                end else begin
                    mdu_io.stall = 1'b1;
                    step_mul     = (state_q == MUL);
                    step_div     = (state_q == DIV);
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == ITER_CNT_W'(XLEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d          = IDLE;
                mdu_io.res_valid = ~mdu_io.flush;
                if (!mdu_io.flush) begin
                    res_d    = fix_res;
                    res_rd_d = rd_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            res_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            res_q    <= res_d;
            res_rd_q <= res_rd_d;
        end
    end

    // Live result in DONE; otherwise hold the last delivered one.
    assign mdu_io.res    = (state_q == DONE) ? fix_res : res_q;
    assign mdu_io.res_rd = (state_q == DONE) ? rd_q : res_rd_q;

    muldiv_core u_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_acc_i (load_acc),
        .load_d_i   (mag_b),
        .step_mul_i (step_mul),
        .step_div_i (step_div),
        .acc_o      (acc)
    );

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed RV32M cases, flush and reset
// scenarios, then randomized ops against an arithmetic reference model.
module tb_ex_muldiv_seq;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ex_muldiv_seq_if bus ();

    ex_muldiv_seq u_dut (
        .clk    (clk),
        .rst    (rst),
        .mdu_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain RV32M arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, zb;
        logic [63:0]        ua, ub, p;
        logic signed [31:0] a_s, b_s;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        zb  = {32'b0, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        a_s = a;
        b_s = b;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * zb; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return a_s / b_s;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return a_s % b_s;
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op in IDLE, hold it until the result pulse, check result/rd/latency/stall.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int n;
        bit got;
        bit stall_bad;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.funct3   = f3;
        bus.opr_a    = a;
        bus.opr_b    = b;
        bus.rd       = rd;
        #1;
        check_eq({tag, "_stall_accept"}, 32'(bus.stall), 32'd1);
        check_eq({tag, "_no_early_valid"}, 32'(bus.res_valid), 32'd0);
        n         = 0;
        got       = 1'b0;
        stall_bad = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (bus.res_valid) got = 1'b1;
            else if (!bus.stall) stall_bad = 1'b1;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'(ref_lat(f3, a, b)));
        check_eq({tag, "_res"}, bus.res, ref_res(f3, a, b));
        check_eq({tag, "_rd"}, 32'(bus.res_rd), 32'(rd));
        check_eq({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
        check_eq({tag, "_stall_busy"}, 32'(stall_bad), 32'd0);
        bus.op_valid = 1'b0;
    endtask

    initial begin
        int any_valid;
        logic [2:0]  f3;
        logic [31:0] a, b;
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        bus.funct3   = '0;
        bus.opr_a    = '0;
        bus.opr_b    = '0;
        bus.rd       = '0;
        bus.flush    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", 32'(bus.stall), 32'd0);
        check_eq("rst_valid", 32'(bus.res_valid), 32'd0);
        check_eq("rst_res", bus.res, 32'd0);
        check_eq("rst_rd", 32'(bus.res_rd), 32'd0);
        rst = 1'b0;

        run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4);
        run_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
        run_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd7);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 5'd8);
        run_op("rem_by0", 3'd6, 32'd5, 32'd0, 5'd9);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op("divu_big", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

        // Flush a divide mid-iteration.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.funct3   = 3'd4;
        bus.opr_a    = 32'd1000;
        bus.opr_b    = 32'd3;
        bus.rd       = 5'd20;
        repeat (11) @(negedge clk);
        bus.flush    = 1'b1;
        bus.op_valid = 1'b0;
        #1;
        check_eq("flush_stall", 32'(bus.stall), 32'd0);
        check_eq("flush_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        any_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.res_valid || bus.stall) any_valid++;
            @(negedge clk);
        end
        check_eq("flush_quiet", 32'(any_valid), 32'd0);
        run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd21);

        // Reset with a simultaneous flush in the middle of a multiply.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.funct3   = 3'd0;
        bus.opr_a    = 32'd1234;
        bus.opr_b    = 32'd5678;
        bus.rd       = 5'd22;
        repeat (6) @(negedge clk);
        rst          = 1'b1;
        bus.flush    = 1'b1;
        bus.op_valid = 1'b0;
        @(negedge clk);
        check_eq("midrst_stall", 32'(bus.stall), 32'd0);
        check_eq("midrst_valid", 32'(bus.res_valid), 32'd0);
        check_eq("midrst_res", bus.res, 32'd0);
        check_eq("midrst_rd", 32'(bus.res_rd), 32'd0);
        rst       = 1'b0;
        bus.flush = 1'b0;

        // Randomized back-to-back ops with biased divisors.
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 16));
                3: b = -32'($urandom_range(1, 16));
                default: ;
            endcase
            run_op("rand", f3, a, b, 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
